pipe_ctrl: RTL

Pipeline sequencing controller for the five-stage CPU. It drives the load enables, bubble and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, branch flushes and multi-cycle data-memory accesses through a req/ack handshake. It sits beside the hazard-detection and forwarding logic, and its outputs feed the enable/flush pins of every pipeline register.

---
 rtl/pipe_ctrl_if.sv | 44 ++++
 rtl/pipe_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipe_ctrl_if : hazard inputs, dmem handshake and pipeline-register controls
// Rev 1.0
// ============================================================================
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start_i;
    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_Rt_i;
    logic [4:0]       IFID_Rs_i;
    logic [4:0]       IFID_Rt_i;
    logic             Branch_taken_i;
    logic             EXMEM_MemRead_i;
    logic             EXMEM_MemWrite_i;
    logic             dmem_ack_i;
    logic             PC_en_o;
    logic             IFID_en_o;
    logic             IDEX_en_o;
    logic             EXMEM_en_o;
    logic             MEMWB_en_o;
    logic             IFID_flush_o;
    logic             IDEX_bubble_o;
    logic             dmem_req_o;
    logic             err_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport slave (
        input  start_i, IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i,
               Branch_taken_i, EXMEM_MemRead_i, EXMEM_MemWrite_i, dmem_ack_i,
        output PC_en_o, IFID_en_o, IDEX_en_o, EXMEM_en_o, MEMWB_en_o,
               IFID_flush_o, IDEX_bubble_o, dmem_req_o, err_o, state_o, stall_cnt_o
    );

    modport master (
        output start_i, IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i,
               Branch_taken_i, EXMEM_MemRead_i, EXMEM_MemWrite_i, dmem_ack_i,
        input  PC_en_o, IFID_en_o, IDEX_en_o, EXMEM_en_o, MEMWB_en_o,
               IFID_flush_o, IDEX_bubble_o, dmem_req_o, err_o, state_o, stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_ctrl : five-stage pipeline sequencer (load-use, branch flush, dmem wait)
// Rev 1.0
// ============================================================================
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    pipe_ctrl_if.slave bus
);
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              err_q, err_d;

    logic mem_op, load_use, issue, req;
    logic pc_en, ifid_en, flush, bubble;

    assign mem_op   = bus.EXMEM_MemRead_i | bus.EXMEM_MemWrite_i;
    assign load_use = bus.IDEX_MemRead_i && (bus.IDEX_Rt_i != 5'd0) &&
                      ((bus.IDEX_Rt_i == bus.IFID_Rs_i) || (bus.IDEX_Rt_i == bus.IFID_Rt_i));

    // issue marks a cycle in which the pipe advances and hazards are resolved
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        issue   = 1'b0;
        req     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (mem_op && !bus.dmem_ack_i) begin
                    req     = 1'b1;
                    state_d = S_WAIT;
                    wait_d  = WAIT_W'(1);
                end else begin
                    issue = 1'b1;
                    req   = mem_op;
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (bus.dmem_ack_i) begin
                    issue   = 1'b1;
                    state_d = S_RUN;
                end else if ((MEM_TIMEOUT != 0) && (wait_q == TIMEOUT_VAL)) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Load-use outranks branch: the branch operands are stale during a load-use stall
    always_comb begin
        pc_en   = issue;
        ifid_en = issue;
        flush   = 1'b0;
        bubble  = 1'b0;
        if (issue && load_use) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            bubble  = 1'b1;
        end else if (issue && bus.Branch_taken_i) begin
            flush = 1'b1;
        end
    end

    always_comb begin
        err_d   = err_q | (state_d == S_ERR);
        stall_d = stall_q;
        if (((state_q == S_RUN) || (state_q == S_WAIT)) && !pc_en && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign bus.PC_en_o       = pc_en;
    assign bus.IFID_en_o     = ifid_en;
    assign bus.IDEX_en_o     = issue;
    assign bus.EXMEM_en_o    = issue;
    assign bus.MEMWB_en_o    = issue;
    assign bus.IFID_flush_o  = flush;
    assign bus.IDEX_bubble_o = bubble;
    assign bus.dmem_req_o    = req;
    assign bus.err_o         = err_q;
    assign bus.state_o       = state_q;
    assign bus.stall_cnt_o   = stall_q;
endmodule
`default_nettype wire
